// File: rtl/cpu_pkg.sv
// Constants shared by the DX decode, stall logic and the multiply/divide engine.
package cpu_pkg;

  localparam logic [4:0] ALUOP_MULT = 5'b00110;
  localparam logic [4:0] ALUOP_DIV  = 5'b00111;

  typedef enum logic [1:0] {
    MD_IDLE = 2'b00,
    MD_MULT = 2'b01,
    MD_DIV  = 2'b10,
    MD_DONE = 2'b11
  } md_state_e;

  // The stall logic needs the same notion of "iterating" as the engine.
  function automatic logic md_is_busy(input md_state_e s);
    return (s == MD_MULT) || (s == MD_DIV);
  endfunction

endpackage

// File: rtl/restoring_div_step.sv
// One restoring-division iteration on unsigned magnitudes: shift in the next
// dividend bit, trial-subtract the divisor, keep the difference if it fits.
module restoring_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH:0]   dvsr_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quo_o
);

  logic [WIDTH:0] shifted_s;
  logic [WIDTH:0] trial_s;

  // Since rem < divisor, shifted-divisor lies within +/-2^WIDTH, so the sign bit is the borrow.
  always_comb begin
    shifted_s = {rem_i, quo_i[WIDTH-1]};
    trial_s   = shifted_s - dvsr_i;
    if (!trial_s[WIDTH]) begin
      rem_o = trial_s[WIDTH-1:0];
      quo_o = {quo_i[WIDTH-2:0], 1'b1};
    end else begin
      rem_o = shifted_s[WIDTH-1:0];
      quo_o = {quo_i[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/multdiv_unit.sv
// Multi-cycle signed multiply (radix-2 Booth) / divide (restoring) engine
// beside the ALU; fixed WIDTH+1 cycle latency from start to result-ready.
module multdiv_unit
  import cpu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic [4:0]       rd_in,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic [4:0]       rd_out,
  output logic             busy
);

  md_state_e          state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [2*WIDTH:0]   prod_q, prod_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   quo_q, quo_d;
  logic [WIDTH:0]     dvsr_q, dvsr_d;
  logic               neg_q, neg_d;
  logic               dz_q, dz_d;
  logic [4:0]         rd_q, rd_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               exc_q, exc_d;
  logic               rdy_q, rdy_d;
  logic               busy_q, busy_d;

  logic [WIDTH:0]     upper_ext_s, mc_ext_s, booth_sum_s;
  logic [2*WIDTH:0]   prod_step_s;
  logic               mult_ovf_s;
  logic [WIDTH-1:0]   rem_step_s, quo_step_s;
  logic [WIDTH-1:0]   div_res_s;
  logic               div_exc_s;
  logic [WIDTH-1:0]   a_mag_s, b_mag_s;
  logic               last_s;

  // Magnitudes read as unsigned, so |0x80000000| stays 0x80000000 instead of wrapping negative.
  assign a_mag_s = data_operandA[WIDTH-1] ? ({WIDTH{1'b0}} - data_operandA) : data_operandA;
  assign b_mag_s = data_operandB[WIDTH-1] ? ({WIDTH{1'b0}} - data_operandB) : data_operandB;
  assign last_s  = (count_q == CNT_W'(WIDTH - 1));

  // Booth step: the partial sum is kept one bit wider so a most-negative multiplicand cannot corrupt the shifted-in sign.
  always_comb begin
    upper_ext_s = {prod_q[2*WIDTH], prod_q[2*WIDTH:WIDTH+1]};
    mc_ext_s    = {mcand_q[WIDTH-1], mcand_q};
    case (prod_q[1:0])
      2'b01:   booth_sum_s = upper_ext_s + mc_ext_s;
      2'b10:   booth_sum_s = upper_ext_s - mc_ext_s;
      default: booth_sum_s = upper_ext_s;
    endcase
    prod_step_s = {booth_sum_s, prod_q[WIDTH:1]};
    mult_ovf_s  = ~((&prod_step_s[2*WIDTH:WIDTH]) | ~(|prod_step_s[2*WIDTH:WIDTH]));
  end

  restoring_div_step #(.WIDTH(WIDTH)) u_div_step (
    .rem_i  (rem_q),
    .quo_i  (quo_q),
    .dvsr_i (dvsr_q),
    .rem_o  (rem_step_s),
    .quo_o  (quo_step_s)
  );

  // Final signed quotient; only +2^(WIDTH-1) (MIN / -1) can exceed the positive range.
  always_comb begin
    if (dz_q) begin
      div_res_s = {WIDTH{1'b0}};
      div_exc_s = 1'b1;
    end else begin
      div_res_s = neg_q ? ({WIDTH{1'b0}} - quo_step_s) : quo_step_s;
      div_exc_s = ~neg_q & quo_step_s[WIDTH-1];
    end
  end

  // Next-state and datapath control.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    prod_d   = prod_q;
    mcand_d  = mcand_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvsr_d   = dvsr_q;
    neg_d    = neg_q;
    dz_d     = dz_q;
    rd_d     = rd_q;
    result_d = result_q;
    exc_d    = exc_q;
    rdy_d    = 1'b0;
    case (state_q)
      MD_IDLE, MD_DONE: begin
        if (ctrl_MULT) begin
          state_d = MD_MULT;
          count_d = {CNT_W{1'b0}};
          prod_d  = {{WIDTH{1'b0}}, data_operandB, 1'b0};
          mcand_d = data_operandA;
          rd_d    = rd_in;
        end else if (ctrl_DIV) begin
          state_d = MD_DIV;
          count_d = {CNT_W{1'b0}};
          rem_d   = {WIDTH{1'b0}};
          quo_d   = a_mag_s;
          dvsr_d  = {1'b0, b_mag_s};
          neg_d   = data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
          dz_d    = (data_operandB == {WIDTH{1'b0}});
          rd_d    = rd_in;
        end else begin
          state_d = MD_IDLE;
        end
      end
      MD_MULT: begin
        prod_d  = prod_step_s;
        count_d = count_q + CNT_W'(1);
        if (last_s) begin
          state_d  = MD_DONE;
          result_d = prod_step_s[WIDTH:1];
          exc_d    = mult_ovf_s;
          rdy_d    = 1'b1;
        end else begin
          state_d = MD_MULT;
        end
      end
      MD_DIV: begin
        rem_d   = rem_step_s;
        quo_d   = quo_step_s;
        count_d = count_q + CNT_W'(1);
        if (last_s) begin
          state_d  = MD_DONE;
          result_d = div_res_s;
          exc_d    = div_exc_s;
          rdy_d    = 1'b1;
        end else begin
          state_d = MD_DIV;
        end
      end
      default: begin
        state_d = MD_IDLE;
      end
    endcase
    busy_d = md_is_busy(state_d);
  end

  // State and output registers; reset also aborts an operation in flight.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= MD_IDLE;
      count_q  <= {CNT_W{1'b0}};
      prod_q   <= {(2*WIDTH+1){1'b0}};
      mcand_q  <= {WIDTH{1'b0}};
      rem_q    <= {WIDTH{1'b0}};
      quo_q    <= {WIDTH{1'b0}};
      dvsr_q   <= {(WIDTH+1){1'b0}};
      neg_q    <= 1'b0;
      dz_q     <= 1'b0;
      rd_q     <= 5'd0;
      result_q <= {WIDTH{1'b0}};
      exc_q    <= 1'b0;
      rdy_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      prod_q   <= prod_d;
      mcand_q  <= mcand_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvsr_q   <= dvsr_d;
      neg_q    <= neg_d;
      dz_q     <= dz_d;
      rd_q     <= rd_d;
      result_q <= result_d;
      exc_q    <= exc_d;
      rdy_q    <= rdy_d;
      busy_q   <= busy_d;
    end
  end

  assign data_result    = result_q;
  assign data_exception = exc_q;
  assign data_resultRDY = rdy_q;
  assign rd_out         = rd_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_multdiv_unit.sv
// Self-checking bench for multdiv_unit: a cycle-level behavioural model driven
// from plain signed arithmetic, directed cases with literal answers, then random traffic.
module tb_multdiv_unit;

  logic        clock;
  logic        reset;
  logic        ctrl_MULT;
  logic        ctrl_DIV;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic [4:0]  rd_in;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;
  logic [4:0]  rd_out;
  logic        busy;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  // model state: cycles left in the op in flight, pending answer, visible outputs
  int          mdl_left;
  logic [31:0] pend_res;
  logic        pend_exc;
  logic [31:0] mdl_res;
  logic        mdl_exc;
  logic        mdl_rdy;
  logic [4:0]  mdl_rd;

  multdiv_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clock          (clock),
    .reset          (reset),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .rd_in          (rd_in),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .rd_out         (rd_out),
    .busy           (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic mdl_step(input logic rst, input logic m, input logic d,
                          input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    longint p;
    longint q;
    if (rst) begin
      mdl_left = 0;
      mdl_rdy  = 1'b0;
      mdl_res  = 32'd0;
      mdl_exc  = 1'b0;
      mdl_rd   = 5'd0;
    end else begin
      mdl_rdy = 1'b0;
      if (mdl_left > 0) begin
        mdl_left--;
        if (mdl_left == 0) begin
          mdl_rdy = 1'b1;
          mdl_res = pend_res;
          mdl_exc = pend_exc;
        end
      end else if (m) begin
        p        = longint'($signed(a)) * longint'($signed(b));
        pend_res = p[31:0];
        pend_exc = (p != longint'($signed(p[31:0])));
        mdl_left = 32;
        mdl_rd   = rd;
      end else if (d) begin
        if (b == 32'd0) begin
          pend_res = 32'd0;
          pend_exc = 1'b1;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          pend_res = 32'h8000_0000;
          pend_exc = 1'b1;
        end else begin
          q        = longint'($signed(a)) / longint'($signed(b));
          pend_res = q[31:0];
          pend_exc = 1'b0;
        end
        mdl_left = 32;
        mdl_rd   = rd;
      end
    end
  endtask

  // Every cycle after the first reset: DUT outputs against the model.
  always @(negedge clock) begin
    if (chk_en) begin
      check("rdy",    {31'd0, data_resultRDY}, {31'd0, mdl_rdy});
      check("busy",   {31'd0, busy},           {31'd0, (mdl_left > 0)});
      check("result", data_result,             mdl_res);
      check("exc",    {31'd0, data_exception}, {31'd0, mdl_exc});
      check("rd_out", {27'd0, rd_out},         {27'd0, mdl_rd});
    end
  end

  task automatic tick(input logic rst, input logic m, input logic d,
                      input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    @(negedge clock);
    #1;
    reset         = rst;
    ctrl_MULT     = m;
    ctrl_DIV      = d;
    data_operandA = a;
    data_operandB = b;
    rd_in         = rd;
    mdl_step(rst, m, d, a, b, rd);
  endtask

  task automatic idle();
    tick(1'b0, 1'b0, 1'b0, $urandom, $urandom, 5'($urandom));
  endtask

  // Start an op, wait (bounded) for RDY, pin latency/busy/result to literals.
  task automatic run_op(input string name, input logic m, input logic d,
                        input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd,
                        input logic [31:0] exp_res, input logic exp_exc, input int inj_k);
    int  k;
    int  busy_n;
    bit  seen;
    tick(1'b0, m, d, a, b, rd);
    k = 0; busy_n = 0; seen = 1'b0;
    while (!seen && k < 40) begin
      k++;
      if (k == inj_k) tick(1'b0, 1'b1, 1'b0, 32'd9, 32'd9, 5'd3);
      else idle();
      if (busy) busy_n++;
      if (data_resultRDY) seen = 1'b1;
    end
    check($sformatf("%s_latency", name), k, 33);
    check($sformatf("%s_busy_cycles", name), busy_n, 32);
    check($sformatf("%s_result", name), data_result, exp_res);
    check($sformatf("%s_exc", name), {31'd0, data_exception}, {31'd0, exp_exc});
    check($sformatf("%s_rd", name), {27'd0, rd_out}, {27'd0, rd});
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: pick = 32'd0;
      1: pick = 32'd1;
      2: pick = 32'hFFFF_FFFF;
      3: pick = 32'h8000_0000;
      4: pick = 32'h7FFF_FFFF;
      5: pick = 32'($urandom_range(0, 255));
      6: pick = 32'd0 - 32'($urandom_range(1, 255));
      default: pick = $urandom;
    endcase
  endfunction

  initial begin
    int n;
    reset = 1'b1; ctrl_MULT = 1'b0; ctrl_DIV = 1'b0;
    data_operandA = 32'd0; data_operandB = 32'd0; rd_in = 5'd0;

    tick(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
    chk_en = 1'b1;
    idle();
    check("reset_busy",   {31'd0, busy},           32'd0);
    check("reset_rdy",    {31'd0, data_resultRDY}, 32'd0);
    check("reset_result", data_result,             32'd0);
    check("reset_rd",     {27'd0, rd_out},         32'd0);

    run_op("mul_7x-3",     1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD, 5'd1, 32'hFFFF_FFEB, 1'b0, 0);
    run_op("mul_ovf",      1'b1, 1'b0, 32'h0001_0000, 32'h0001_0000, 5'd2, 32'h0000_0000, 1'b1, 0);
    run_op("mul_max",      1'b1, 1'b0, 32'h7FFF_FFFF, 32'd1, 5'd3, 32'h7FFF_FFFF, 1'b0, 0);
    run_op("mul_min_min",  1'b1, 1'b0, 32'h8000_0000, 32'h8000_0000, 5'd4, 32'h0000_0000, 1'b1, 0);
    run_op("div_-7/2",     1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, 5'd5, 32'hFFFF_FFFD, 1'b0, 0);
    run_op("div_5/0",      1'b0, 1'b1, 32'd5, 32'd0, 5'd6, 32'd0, 1'b1, 0);
    run_op("div_min/-1",   1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 5'd7, 32'h8000_0000, 1'b1, 0);
    run_op("div_min/1",    1'b0, 1'b1, 32'h8000_0000, 32'd1, 5'd8, 32'h8000_0000, 1'b0, 0);
    run_op("div_100/7",    1'b0, 1'b1, 32'd100, 32'd7, 5'd12, 32'd14, 1'b0, 10);

    n = 0;
    for (int i = 0; i < 36; i++) begin
      idle();
      if (data_resultRDY) n++;
    end
    check("div_100/7_extra_rdy", n, 0);

    run_op("both_start",   1'b1, 1'b1, 32'd6, 32'd3, 5'd9, 32'd18, 1'b0, 0);
    run_op("start_in_done", 1'b0, 1'b1, 32'hFFFF_FF9C, 32'd7, 5'd10, 32'hFFFF_FFF2, 1'b0, 0);

    tick(1'b0, 1'b0, 1'b1, 32'd1000, 32'd3, 5'd4);
    for (int i = 0; i < 14; i++) idle();
    tick(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
    idle();
    check("abort_busy",   {31'd0, busy},           32'd0);
    check("abort_rdy",    {31'd0, data_resultRDY}, 32'd0);
    check("abort_result", data_result,             32'd0);
    check("abort_exc",    {31'd0, data_exception}, 32'd0);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      idle();
      if (data_resultRDY) n++;
    end
    check("abort_no_rdy", n, 0);
    run_op("mul_2x3",      1'b1, 1'b0, 32'd2, 32'd3, 5'd11, 32'd6, 1'b0, 0);

    for (int i = 0; i < 2500; i++) begin
      int r;
      r = $urandom_range(0, 99);
      tick((r == 0), (r >= 1 && r <= 6), (r >= 5 && r <= 11), pick(), pick(), 5'($urandom));
    end
    for (int i = 0; i < 40; i++) idle();

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
